output_bcd_converter: RTL

Parametrised binary-to-BCD converter for the display output path. It converts a `WIDTH`-bit binary value into `DIGITS` packed BCD digits using iterative divide-by-10, producing one digit per clock. Conversion runs under a start/done handshake and flags values that do not fit in `DIGITS` digits. It sits between the CPU output register and the seven-segment drivers, replacing the free-running fixed 16-bit/4-digit divider.

---
 rtl/output_bcd_converter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/output_bcd_converter.sv
// Binary-to-BCD converter for the display output path.
// Iterative divide-by-10, one digit per clock, start/done handshake, overflow flag.
// Optional signed input: define OUTPUT_BCD_SIGNED_EN to treat `data` as two's complement
// and report the sign on `neg`; otherwise `neg` is tied low and no sign logic exists.
module output_bcd_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  neg
);

    localparam int unsigned CntW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      num_q, num_d;
    logic [4*DIGITS-1:0]   shreg_q, shreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic [WIDTH-1:0]      mag;
    logic [3:0]            digit;

`ifdef OUTPUT_BCD_SIGNED_EN
    logic                  sign_q, sign_d;
    logic                  neg_q, neg_d;

    // Unsigned WIDTH-bit negate so the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        mag = data[WIDTH-1] ? (~data + WIDTH'(1)) : data;
    end
`else
    always_comb begin
        mag = data;
    end
`endif

    // Next-state logic for the conversion FSM and its working registers.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        digit   = 4'(num_q % WIDTH'(10));
`ifdef OUTPUT_BCD_SIGNED_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d   = mag;
                    shreg_d = '0;
                    cnt_d   = '0;
`ifdef OUTPUT_BCD_SIGNED_EN
                    sign_d  = data[WIDTH-1];
`endif
                    state_d = StConv;
                end
            end
            StConv: begin
                num_d = num_q / WIDTH'(10);
                // New digit enters at the top; after DIGITS shifts the first lands in digit 0.
                shreg_d = shreg_q >> 4;
                shreg_d[4*DIGITS-1 -: 4] = digit;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DIGITS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = shreg_q;
                ovf_d   = (num_q != '0);
`ifdef OUTPUT_BCD_SIGNED_EN
                neg_d   = sign_q;
`endif
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            num_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef OUTPUT_BCD_SIGNED_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef OUTPUT_BCD_SIGNED_EN
            sign_q  <= sign_d;
            neg_q   <= neg_d;
`endif
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy     = (state_q != StIdle);
        done     = done_q;
        bcd      = bcd_q;
        overflow = ovf_q;
`ifdef OUTPUT_BCD_SIGNED_EN
        neg      = neg_q;
`else
        neg      = 1'b0;
`endif
    end

endmodule
